// File: rtl/sgd_dot_grad_scale.sv
// Per-sample dot-product accumulate, label subtract, power-of-two scale and saturate.
// Latency: last chunk in cycle T -> grad_out_valid in T+2; dot input is never backpressured.

module sgd_label_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    // Full blocks a push even when the same cycle pops: ready stays conservative.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module sgd_dot_grad_scale #(
    parameter int NUM_CHUNKS_WIDTH = 10,
    parameter int LABEL_FIFO_DEPTH = 16,
    parameter int ACC_WIDTH        = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHUNKS_WIDTH-1:0] num_chunks,
    input  logic [4:0]                  step_shift,
    input  logic signed [31:0]          dot_in,
    input  logic                        dot_in_valid,
    input  logic signed [31:0]          label_in,
    input  logic                        label_in_valid,
    output logic                        label_in_ready,
    output logic signed [31:0]          grad_out,
    output logic                        grad_out_valid,
    output logic                        grad_sat,
    output logic                        label_err,
    output logic [31:0]                 sample_cnt
);
    localparam int NCW = NUM_CHUNKS_WIDTH;
    localparam int DW  = ACC_WIDTH + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [NCW-1:0]         chunk_cnt_q, chunk_cnt_d;
    logic [NCW-1:0]         nc_q, nc_d;
    logic signed [DW-1:0]   diff_q, diff_d;
    logic [4:0]             shift_q, shift_d;
    logic                   s1_vld_q, s1_vld_d;
    logic                   label_err_q, label_err_d;
    logic signed [31:0]     grad_q;
    logic                   grad_vld_q;
    logic                   grad_sat_q;
    logic [31:0]            sample_cnt_q;

    logic [31:0]            fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    logic [NCW-1:0]         eff_nc;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic [31:0]            label_val;
    logic                   is_last;
    logic signed [DW-1:0]   sh;
    logic                   sat_hi;
    logic                   sat_lo;
    logic signed [31:0]     grad_d;

    sgd_label_fifo #(
        .W     (32),
        .DEPTH (LABEL_FIFO_DEPTH)
    ) u_label_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (label_in_valid),
        .push_dat_i (label_in),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign label_in_ready = !fifo_full;
    assign eff_nc    = (num_chunks == '0) ? NCW'(1) : num_chunks;
    assign acc_sum   = acc_q + {{(ACC_WIDTH-32){dot_in[31]}}, dot_in};
    // An empty FIFO at sample completion substitutes label 0.
    assign label_val = fifo_empty ? 32'd0 : fifo_head;
    assign is_last   = (state_q == IDLE) ? (eff_nc == NCW'(1))
                                         : (chunk_cnt_q == nc_q - NCW'(1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        chunk_cnt_d = chunk_cnt_q;
        nc_d        = nc_q;
        diff_d      = diff_q;
        shift_d     = shift_q;
        s1_vld_d    = 1'b0;
        label_err_d = label_err_q;
        fifo_pop    = 1'b0;
        if (dot_in_valid) begin
            if (is_last) begin
                diff_d      = {acc_sum[ACC_WIDTH-1], acc_sum}
                            - {{(DW-32){label_val[31]}}, label_val};
                shift_d     = step_shift;
                s1_vld_d    = 1'b1;
                fifo_pop    = 1'b1;
                label_err_d = label_err_q | fifo_empty;
                acc_d       = '0;
                chunk_cnt_d = '0;
                state_d     = IDLE;
            end else begin
                acc_d       = acc_sum;
                chunk_cnt_d = chunk_cnt_q + NCW'(1);
                if (state_q == IDLE) begin
                    nc_d    = eff_nc;
                    state_d = ACCUM;
                end
            end
        end
    end

    // The result fits in 32 bits only when bits [DW-1:31] are all equal.
    assign sh     = diff_q >>> shift_q;
    assign sat_hi = !sh[DW-1] && (|sh[DW-2:31]);
    assign sat_lo = sh[DW-1] && !(&sh[DW-2:31]);
    assign grad_d = sat_hi ? 32'sh7FFFFFFF :
                    sat_lo ? 32'sh80000000 : sh[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            chunk_cnt_q  <= '0;
            nc_q         <= NCW'(1);
            diff_q       <= '0;
            shift_q      <= '0;
            s1_vld_q     <= 1'b0;
            label_err_q  <= 1'b0;
            grad_q       <= '0;
            grad_vld_q   <= 1'b0;
            grad_sat_q   <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            chunk_cnt_q  <= chunk_cnt_d;
            nc_q         <= nc_d;
            diff_q       <= diff_d;
            shift_q      <= shift_d;
            s1_vld_q     <= s1_vld_d;
            label_err_q  <= label_err_d;
            grad_vld_q   <= s1_vld_q;
            grad_sat_q   <= s1_vld_q && (sat_hi || sat_lo);
            if (s1_vld_q) begin
                grad_q       <= grad_d;
                sample_cnt_q <= sample_cnt_q + 32'd1;
            end
        end
    end

    assign grad_out       = grad_q;
    assign grad_out_valid = grad_vld_q;
    assign grad_sat       = grad_sat_q;
    assign label_err      = label_err_q;
    assign sample_cnt     = sample_cnt_q;
endmodule

// File: tb/tb_sgd_dot_grad_scale.sv
// Directed bench for sgd_dot_grad_scale with hand-computed expected values.
module tb_sgd_dot_grad_scale;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [9:0]         num_chunks = 10'd1;
    logic [4:0]         step_shift = 5'd0;
    logic signed [31:0] dot_in = '0;
    logic               dot_in_valid = 1'b0;
    logic signed [31:0] label_in = '0;
    logic               label_in_valid = 1'b0;
    logic               label_in_ready;
    logic signed [31:0] grad_out;
    logic               grad_out_valid;
    logic               grad_sat;
    logic               label_err;
    logic [31:0]        sample_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    sgd_dot_grad_scale dut (
        .clk            (clk),
        .rst            (rst),
        .num_chunks     (num_chunks),
        .step_shift     (step_shift),
        .dot_in         (dot_in),
        .dot_in_valid   (dot_in_valid),
        .label_in       (label_in),
        .label_in_valid (label_in_valid),
        .label_in_ready (label_in_ready),
        .grad_out       (grad_out),
        .grad_out_valid (grad_out_valid),
        .grad_sat       (grad_sat),
        .label_err      (label_err),
        .sample_cnt     (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (grad_out_valid === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_label(input logic signed [31:0] v);
        label_in = v;
        label_in_valid = 1'b1;
        tick();
        label_in_valid = 1'b0;
    endtask

    task automatic send_dot(input logic signed [31:0] v);
        dot_in = v;
        dot_in_valid = 1'b1;
        tick();
        dot_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (grad_out !== 32'sd0) begin errors++; $display("FAIL reset_grad got %0d want 0", grad_out); end
        checks++; if (grad_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", grad_out_valid); end
        checks++; if (grad_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", grad_sat); end
        checks++; if (label_err !== 1'b0) begin errors++; $display("FAIL reset_label_err got %b want 0", label_err); end
        checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL reset_sample_cnt got %0d want 0", sample_cnt); end
        checks++; if (label_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", label_in_ready); end
    endtask

    task automatic test_single();
        num_chunks = 10'd1;
        step_shift = 5'd0;
        push_label(32'sd5);
        send_dot(32'sd12);
        checks++; if (grad_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", grad_out_valid); end
        tick();
        checks++; if (grad_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", grad_out_valid); end
        checks++; if (grad_out !== 32'sd7) begin errors++; $display("FAIL single_grad got %0d want 7", grad_out); end
        checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL single_sample_cnt got %0d want 1", sample_cnt); end
        checks++; if (grad_sat !== 1'b0) begin errors++; $display("FAIL single_sat got %b want 0", grad_sat); end
    endtask

    task automatic test_multi_chunk();
        int p0;
        push_label(32'sd50);
        num_chunks = 10'd3;
        step_shift = 5'd2;
        p0 = pulses;
        send_dot(32'sd100);
        num_chunks = 10'd1;
        send_dot(-32'sd20);
        tick();
        send_dot(32'sd4);
        checks++; if (grad_out_valid !== 1'b0) begin errors++; $display("FAIL multi_early_valid got %b want 0", grad_out_valid); end
        tick();
        checks++; if (grad_out_valid !== 1'b1) begin errors++; $display("FAIL multi_valid got %b want 1", grad_out_valid); end
        checks++; if (grad_out !== 32'sd8) begin errors++; $display("FAIL multi_grad got %0d want 8", grad_out); end
        tick();
        checks++; if (grad_out_valid !== 1'b0) begin errors++; $display("FAIL multi_valid_drop got %b want 0", grad_out_valid); end
        checks++; if (grad_out !== 32'sd8) begin errors++; $display("FAIL multi_grad_hold got %0d want 8", grad_out); end
        tick();
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL multi_pulse_count got %0d want 1", pulses - p0); end
        num_chunks = 10'd1;
    endtask

    task automatic test_floor();
        push_label(32'sd0);
        num_chunks = 10'd1;
        step_shift = 5'd1;
        send_dot(-32'sd7);
        tick();
        checks++; if (grad_out !== -32'sd4) begin errors++; $display("FAIL floor_grad got %0d want -4", grad_out); end
        checks++; if (grad_sat !== 1'b0) begin errors++; $display("FAIL floor_sat got %b want 0", grad_sat); end
    endtask

    task automatic test_saturation();
        num_chunks = 10'd2;
        step_shift = 5'd0;
        push_label(-32'sd1);
        send_dot(32'sh7FFFFFFF);
        send_dot(32'sh7FFFFFFF);
        tick();
        checks++; if (grad_out !== 32'sh7FFFFFFF) begin errors++; $display("FAIL sat_hi_grad got %h want 7fffffff", grad_out); end
        checks++; if (grad_sat !== 1'b1) begin errors++; $display("FAIL sat_hi_flag got %b want 1", grad_sat); end
        tick();
        checks++; if (grad_sat !== 1'b0) begin errors++; $display("FAIL sat_flag_pulse got %b want 0", grad_sat); end
        push_label(32'sd1);
        send_dot(32'sh80000000);
        send_dot(32'sh80000000);
        tick();
        checks++; if (grad_out !== 32'sh80000000) begin errors++; $display("FAIL sat_lo_grad got %h want 80000000", grad_out); end
        checks++; if (grad_sat !== 1'b1) begin errors++; $display("FAIL sat_lo_flag got %b want 1", grad_sat); end
    endtask

    task automatic test_back_to_back();
        num_chunks = 10'd1;
        step_shift = 5'd0;
        label_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            label_in = i;
            tick();
        end
        label_in_valid = 1'b0;
        checks++; if (label_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", label_in_ready); end
        dot_in = 32'sd100;
        dot_in_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) dot_in_valid = 1'b0;
            if (k == 1) begin
                checks++; if (label_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop got %b want 1", label_in_ready); end
            end
            if (k >= 2) begin
                checks++; if (grad_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got %b want 1", k - 2, grad_out_valid); end
                checks++; if (grad_out !== 32'sd100 - (k - 2)) begin errors++; $display("FAIL b2b_grad_%0d got %0d want %0d", k - 2, grad_out, 100 - (k - 2)); end
            end
        end
        checks++; if (sample_cnt !== 32'd21) begin errors++; $display("FAIL b2b_sample_cnt got %0d want 21", sample_cnt); end
    endtask

    task automatic test_underflow_reset();
        int p0;
        num_chunks = 10'd1;
        step_shift = 5'd0;
        send_dot(32'sd9);
        tick();
        checks++; if (grad_out !== 32'sd9) begin errors++; $display("FAIL uflow_grad got %0d want 9", grad_out); end
        checks++; if (label_err !== 1'b1) begin errors++; $display("FAIL uflow_label_err got %b want 1", label_err); end
        checks++; if (sample_cnt !== 32'd22) begin errors++; $display("FAIL uflow_sample_cnt got %0d want 22", sample_cnt); end
        num_chunks = 10'd3;
        send_dot(32'sd5);
        send_dot(32'sd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (grad_out !== 32'sd0) begin errors++; $display("FAIL rst2_grad got %0d want 0", grad_out); end
        checks++; if (grad_out_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid got %b want 0", grad_out_valid); end
        checks++; if (grad_sat !== 1'b0) begin errors++; $display("FAIL rst2_sat got %b want 0", grad_sat); end
        checks++; if (label_err !== 1'b0) begin errors++; $display("FAIL rst2_label_err got %b want 0", label_err); end
        checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL rst2_sample_cnt got %0d want 0", sample_cnt); end
        checks++; if (label_in_ready !== 1'b1) begin errors++; $display("FAIL rst2_ready got %b want 1", label_in_ready); end
        p0 = pulses;
        tick();
        tick();
        tick();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL rst2_no_pulse got %0d want 0", pulses - p0); end
        push_label(32'sd1);
        send_dot(32'sd1);
        send_dot(32'sd1);
        send_dot(32'sd1);
        tick();
        checks++; if (grad_out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", grad_out_valid); end
        checks++; if (grad_out !== 32'sd2) begin errors++; $display("FAIL post_rst_grad got %0d want 2", grad_out); end
        checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL post_rst_sample_cnt got %0d want 1", sample_cnt); end
        checks++; if (label_err !== 1'b0) begin errors++; $display("FAIL post_rst_label_err got %b want 0", label_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_chunk();
        test_floor();
        test_saturation();
        test_back_to_back();
        test_underflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
